// File: rtl/alu_whole.sv
// MIPS-style execute-stage ALU: decodes ALUop/funct, computes one operation per
// cycle through a shared adder, and registers the result and flags.
module alu_whole #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       ALUop,
    input  logic [5:0]       Fuc,
    input  logic [WIDTH-1:0] Adat,
    input  logic [WIDTH-1:0] Bdat,
    output logic [WIDTH-1:0] Result,
    output logic             zero,
    output logic             carryout,
    output logic             overflow
);

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_ADDU = 4'd1;
    localparam logic [3:0] OP_SUB  = 4'd2;
    localparam logic [3:0] OP_SUBU = 4'd3;
    localparam logic [3:0] OP_AND  = 4'd4;
    localparam logic [3:0] OP_OR   = 4'd5;
    localparam logic [3:0] OP_XOR  = 4'd6;
    localparam logic [3:0] OP_NOR  = 4'd7;
    localparam logic [3:0] OP_SLT  = 4'd8;
    localparam logic [3:0] OP_SLTU = 4'd9;
    localparam logic [3:0] OP_NONE = 4'd10;

    logic [3:0]       op_sel;
    logic             sub_sel;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   sum_ext;
    logic             ovf_raw;
    logic             less_s;
    logic             less_u;

    logic [WIDTH-1:0] result_d, result_q;
    logic             zero_d, zero_q;
    logic             carry_d, carry_q;
    logic             ovf_d, ovf_q;

    always_comb begin
        op_sel = OP_NONE;
        case (ALUop)
            2'b00: op_sel = OP_ADD;
            2'b01: op_sel = OP_SUB;
            2'b11: op_sel = OP_OR;
            default: begin
                case (Fuc)
                    6'b100000: op_sel = OP_ADD;
                    6'b100001: op_sel = OP_ADDU;
                    6'b100010: op_sel = OP_SUB;
                    6'b100011: op_sel = OP_SUBU;
                    6'b100100: op_sel = OP_AND;
                    6'b100101: op_sel = OP_OR;
                    6'b100110: op_sel = OP_XOR;
                    6'b100111: op_sel = OP_NOR;
                    6'b101010: op_sel = OP_SLT;
                    6'b101011: op_sel = OP_SLTU;
                    default:   op_sel = OP_NONE;
                endcase
            end
        endcase
    end

    // One adder serves add, subtract and both compares: A + ~B + 1 for subtraction.
    always_comb begin
        sub_sel = (op_sel == OP_SUB) || (op_sel == OP_SUBU) ||
                  (op_sel == OP_SLT) || (op_sel == OP_SLTU);
        b_eff   = sub_sel ? ~Bdat : Bdat;
        sum_ext = {1'b0, Adat} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub_sel};
        ovf_raw = (Adat[WIDTH-1] == b_eff[WIDTH-1]) &&
                  (sum_ext[WIDTH-1] != Adat[WIDTH-1]);
        // Sign of the difference corrected by overflow gives the true signed order.
        less_s  = sum_ext[WIDTH-1] ^ ovf_raw;
        less_u  = ~sum_ext[WIDTH];
    end

    always_comb begin
        result_d = '0;
        carry_d  = 1'b0;
        ovf_d    = 1'b0;
        case (op_sel)
            OP_ADD, OP_SUB: begin
                result_d = sum_ext[WIDTH-1:0];
                carry_d  = sum_ext[WIDTH];
                ovf_d    = ovf_raw;
            end
            OP_ADDU, OP_SUBU: begin
                result_d = sum_ext[WIDTH-1:0];
                carry_d  = sum_ext[WIDTH];
            end
            OP_AND:  result_d = Adat & Bdat;
            OP_OR:   result_d = Adat | Bdat;
            OP_XOR:  result_d = Adat ^ Bdat;
            OP_NOR:  result_d = ~(Adat | Bdat);
            OP_SLT:  result_d = {{(WIDTH-1){1'b0}}, less_s};
            OP_SLTU: result_d = {{(WIDTH-1){1'b0}}, less_u};
            default: result_d = '0;
        endcase
        zero_d = (result_d == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_q <= '0;
            zero_q   <= 1'b1;
            carry_q  <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            result_q <= result_d;
            zero_q   <= zero_d;
            carry_q  <= carry_d;
            ovf_q    <= ovf_d;
        end
    end

    assign Result   = result_q;
    assign zero     = zero_q;
    assign carryout = carry_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_alu_whole.sv
// Directed-vector bench for alu_whole: each task applies hand-computed cases
// and compares the registered outputs one cycle later.
`timescale 1ns/1ps
module tb_alu_whole;

    logic        clk;
    logic        rst_n;
    logic [1:0]  ALUop;
    logic [5:0]  Fuc;
    logic [31:0] Adat;
    logic [31:0] Bdat;
    logic [31:0] Result;
    logic        zero;
    logic        carryout;
    logic        overflow;

    int n_vec = 0;
    int n_err = 0;

    alu_whole #(.WIDTH(32)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ALUop    (ALUop),
        .Fuc      (Fuc),
        .Adat     (Adat),
        .Bdat     (Bdat),
        .Result   (Result),
        .zero     (zero),
        .carryout (carryout),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive inputs on the falling edge, then sample 1ns after the next rising edge.
    task automatic apply(input logic [1:0] op, input logic [5:0] f,
                         input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        ALUop = op; Fuc = f; Adat = a; Bdat = b;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        ALUop = 2'b00; Fuc = 6'd0; Adat = 32'h1234_5678; Bdat = 32'h1;
        repeat (3) @(posedge clk);
        #1;
        n_vec++;
        if (Result !== 32'h0 || zero !== 1'b1 || carryout !== 1'b0 || overflow !== 1'b0) begin
            n_err++;
            $display("FAIL reset: got R=%h z=%b c=%b v=%b want R=00000000 z=1 c=0 v=0",
                     Result, zero, carryout, overflow);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_branch_sub;
        apply(2'b01, 6'b100000, 32'd4, 32'd4);
        n_vec++;
        if (Result !== 32'h0 || zero !== 1'b1 || carryout !== 1'b1 || overflow !== 1'b0) begin
            n_err++;
            $display("FAIL aluop01_sub: got R=%h z=%b c=%b v=%b want R=00000000 z=1 c=1 v=0",
                     Result, zero, carryout, overflow);
        end
        $display("vec aluop01 4-4 -> R=%h z=%b c=%b v=%b", Result, zero, carryout, overflow);
    endtask

    task automatic test_add_overflow;
        apply(2'b10, 6'b100000, 32'h7FFF_FFFF, 32'h1);
        n_vec++;
        if (Result !== 32'h8000_0000 || zero !== 1'b0 || carryout !== 1'b0 || overflow !== 1'b1) begin
            n_err++;
            $display("FAIL add_ovf: got R=%h z=%b c=%b v=%b want R=80000000 z=0 c=0 v=1",
                     Result, zero, carryout, overflow);
        end
        $display("vec add 7fffffff+1 -> R=%h v=%b", Result, overflow);
        apply(2'b10, 6'b100001, 32'h7FFF_FFFF, 32'h1);
        n_vec++;
        if (Result !== 32'h8000_0000 || overflow !== 1'b0 || carryout !== 1'b0) begin
            n_err++;
            $display("FAIL addu_noovf: got R=%h c=%b v=%b want R=80000000 c=0 v=0",
                     Result, carryout, overflow);
        end
        $display("vec addu 7fffffff+1 -> R=%h v=%b", Result, overflow);
        apply(2'b10, 6'b100001, 32'hFFFF_FFFF, 32'h1);
        n_vec++;
        if (Result !== 32'h0 || zero !== 1'b1 || carryout !== 1'b1 || overflow !== 1'b0) begin
            n_err++;
            $display("FAIL addu_wrap: got R=%h z=%b c=%b v=%b want R=00000000 z=1 c=1 v=0",
                     Result, zero, carryout, overflow);
        end
        $display("vec addu ffffffff+1 -> R=%h c=%b", Result, carryout);
        // sub: 0x80000000 - 1 overflows signed; no borrow so carry=1
        apply(2'b10, 6'b100010, 32'h8000_0000, 32'h1);
        n_vec++;
        if (Result !== 32'h7FFF_FFFF || carryout !== 1'b1 || overflow !== 1'b1) begin
            n_err++;
            $display("FAIL sub_ovf: got R=%h c=%b v=%b want R=7fffffff c=1 v=1",
                     Result, carryout, overflow);
        end
        $display("vec sub 80000000-1 -> R=%h v=%b", Result, overflow);
        // subu: 1 - 2 borrows so carry=0, no overflow flag
        apply(2'b10, 6'b100011, 32'h1, 32'h2);
        n_vec++;
        if (Result !== 32'hFFFF_FFFF || carryout !== 1'b0 || overflow !== 1'b0 || zero !== 1'b0) begin
            n_err++;
            $display("FAIL subu_borrow: got R=%h z=%b c=%b v=%b want R=ffffffff z=0 c=0 v=0",
                     Result, zero, carryout, overflow);
        end
        $display("vec subu 1-2 -> R=%h c=%b", Result, carryout);
        // ALUop 00 signed add: -1 + -1
        apply(2'b00, 6'b000000, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        n_vec++;
        if (Result !== 32'hFFFF_FFFE || carryout !== 1'b1 || overflow !== 1'b0) begin
            n_err++;
            $display("FAIL aluop00_add: got R=%h c=%b v=%b want R=fffffffe c=1 v=0",
                     Result, carryout, overflow);
        end
        $display("vec aluop00 -1+-1 -> R=%h", Result);
    endtask

    task automatic test_compare;
        apply(2'b10, 6'b101010, 32'hFFFF_FFFF, 32'h1);
        n_vec++;
        if (Result !== 32'h1 || carryout !== 1'b0 || overflow !== 1'b0) begin
            n_err++;
            $display("FAIL slt_neg: got R=%h c=%b v=%b want R=00000001 c=0 v=0",
                     Result, carryout, overflow);
        end
        $display("vec slt -1<1 -> R=%h", Result);
        apply(2'b10, 6'b101011, 32'hFFFF_FFFF, 32'h1);
        n_vec++;
        if (Result !== 32'h0 || zero !== 1'b1) begin
            n_err++;
            $display("FAIL sltu: got R=%h z=%b want R=00000000 z=1", Result, zero);
        end
        $display("vec sltu ffffffff<1 -> R=%h", Result);
        apply(2'b10, 6'b101010, 32'h8000_0000, 32'h1);
        n_vec++;
        if (Result !== 32'h1 || overflow !== 1'b0) begin
            n_err++;
            $display("FAIL slt_ovf: got R=%h v=%b want R=00000001 v=0", Result, overflow);
        end
        $display("vec slt 80000000<1 -> R=%h", Result);
        apply(2'b10, 6'b101010, 32'h5, 32'h5);
        n_vec++;
        if (Result !== 32'h0) begin
            n_err++;
            $display("FAIL slt_equal: got R=%h want R=00000000", Result);
        end
        $display("vec slt 5<5 -> R=%h", Result);
    endtask

    task automatic test_logic;
        logic [1:0]  ops   [6] = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b11, 2'b10};
        logic [5:0]  fucs  [6] = '{6'b100100, 6'b100101, 6'b100110, 6'b100111, 6'b100000, 6'b000000};
        logic [31:0] exps  [6] = '{32'h00F0_00F0, 32'hFFF0_FFF0, 32'hFF00_FF00,
                                   32'h000F_000F, 32'hFFF0_FFF0, 32'h0000_0000};
        for (int i = 0; i < 6; i++) begin
            apply(ops[i], fucs[i], 32'hF0F0_F0F0, 32'h0FF0_0FF0);
            n_vec++;
            if (Result !== exps[i] || zero !== (exps[i] == 32'h0) ||
                carryout !== 1'b0 || overflow !== 1'b0) begin
                n_err++;
                $display("FAIL logic_%0d: got R=%h z=%b c=%b v=%b want R=%h z=%b c=0 v=0",
                         i, Result, zero, carryout, overflow, exps[i], exps[i] == 32'h0);
            end
            $display("vec logic op=%b fuc=%b -> R=%h", ops[i], fucs[i], Result);
        end
    endtask

    task automatic test_back_to_back;
        @(negedge clk);
        ALUop = 2'b10; Fuc = 6'b100001; Adat = 32'h10; Bdat = 32'h20;
        #1;
        n_vec++;
        if (Result !== 32'h0) begin
            n_err++;
            $display("FAIL b2b_latency: got R=%h before edge want R=00000000", Result);
        end
        @(posedge clk);
        #1;
        ALUop = 2'b10; Fuc = 6'b100110; Adat = 32'hAAAA_AAAA; Bdat = 32'hFFFF_FFFF;
        n_vec++;
        if (Result !== 32'h30) begin
            n_err++;
            $display("FAIL b2b_first: got R=%h want R=00000030", Result);
        end
        $display("vec b2b addu 10+20 -> R=%h", Result);
        @(posedge clk);
        #1;
        n_vec++;
        if (Result !== 32'h5555_5555 || zero !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_second: got R=%h z=%b want R=55555555 z=0", Result, zero);
        end
        $display("vec b2b xor -> R=%h", Result);
    endtask

    task automatic test_async_reset;
        apply(2'b10, 6'b100001, 32'hFFFF_FFFF, 32'h2);
        n_vec++;
        if (Result !== 32'h1 || carryout !== 1'b1) begin
            n_err++;
            $display("FAIL pre_reset: got R=%h c=%b want R=00000001 c=1", Result, carryout);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_vec++;
        if (Result !== 32'h0 || zero !== 1'b1 || carryout !== 1'b0 || overflow !== 1'b0) begin
            n_err++;
            $display("FAIL async_reset: got R=%h z=%b c=%b v=%b want R=00000000 z=1 c=0 v=0",
                     Result, zero, carryout, overflow);
        end
        $display("vec async reset -> R=%h z=%b", Result, zero);
        @(negedge clk);
        rst_n = 1'b1;
        apply(2'b00, 6'b000000, 32'h3, 32'h4);
        n_vec++;
        if (Result !== 32'h7 || zero !== 1'b0) begin
            n_err++;
            $display("FAIL post_reset: got R=%h z=%b want R=00000007 z=0", Result, zero);
        end
        $display("vec post reset 3+4 -> R=%h", Result);
    endtask

    initial begin
        test_reset();
        test_branch_sub();
        test_add_overflow();
        test_compare();
        test_logic();
        test_back_to_back();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/alu_whole.md
Name: alu_whole

Overview:
- Combined ALU-control decoder and 32-bit ALU for the single-cycle/pipelined MIPS-style CPU.
- Takes the 2-bit ALUop from main control and the 6-bit funct field from the instruction, and selects the operation.
- Operates on two 32-bit operands and produces a registered result plus zero, carryout and overflow flags.
- Sits in the execute stage between the operand muxes and the EX/MEM boundary.

Parameters:
- WIDTH, 32, datapath width. Only 32 is required to be supported.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous reset, active-low
- ALUop  input  2  operation class from main control
- Fuc  input  6  instruction funct field; used only when ALUop=10
- Adat  input  32  operand A
- Bdat  input  32  operand B
- Result  output  32  registered ALU result
- zero  output  1  registered; 1 when the registered Result is 0
- carryout  output  1  registered carry out of bit 31 of the adder
- overflow  output  1  registered signed-overflow flag

Behaviour:
- Interface: one clock; reset is asynchronous and active-low (ports clk, rst_n).
- All outputs are registered. Inputs are sampled on the rising edge of clk; outputs are valid the following cycle (latency 1). There is no handshake, and a new operation is accepted every cycle.
- Reset, while rst_n=0 and independent of clk:
  - Result=0, zero=1, carryout=0, overflow=0.
  - Normal operation resumes on the first rising edge after rst_n returns to 1.
  - Asserting reset mid-operation discards the pending result.
- ALUop decode:
  - 00 = signed add (load/store address).
  - 01 = signed subtract (branch compare); Fuc is ignored.
  - 10 = R-type, decoded by Fuc.
  - 11 = bitwise OR (immediate logic).
- Fuc decode when ALUop=10:
  - 100000 add: A+B, signed.
  - 100001 addu: A+B, unsigned.
  - 100010 sub: A-B, signed.
  - 100011 subu: A-B, unsigned.
  - 100100 and
  - 100101 or
  - 100110 xor
  - 100111 nor
  - 101010 slt: Result=1 if A<B as signed, else 0.
  - 101011 sltu: Result=1 if A<B as unsigned, else 0.
  - Any other code: Result=0, carryout=0, overflow=0, zero=1.
- Arithmetic:
  - A single 32-bit adder computes A + (B or ~B) + cin, with cin=1 for subtract.
  - carryout = bit 32 of that sum for add, addu, sub and subu. For subtract, carryout=1 means no borrow.
  - carryout=0 for logic ops, slt and sltu.
- overflow:
  - Set only for the signed ops: ALUop 00, ALUop 01, add and sub.
  - For add: operands have the same sign and the result sign differs.
  - For sub: operand signs differ and the result sign differs from A.
  - overflow=0 for all other ops.
  - The result is written even when overflow=1; trapping is not this block's job.
- slt must be correct even when A-B overflows: less = sum[31] XOR overflow_raw.
- zero is computed from the next-state Result and registered alongside it.
- All arithmetic is modulo 2^32 and wraps with no saturation.

Test Plan:
- rst_n=0 with active clk; release it, then apply ALUop=01, Fuc=100000, A=4, B=4 -> next cycle: Result=0, zero=1, carryout=1, overflow=0.
- ALUop=10, Fuc=100000, A=7FFFFFFF, B=1 -> Result=80000000, overflow=1, carryout=0, zero=0. With Fuc=100001 and the same operands -> same Result, overflow=0.
- ALUop=10, Fuc=100001, A=FFFFFFFF, B=1 -> Result=0, zero=1, carryout=1, overflow=0.
- ALUop=10, Fuc=101010, A=FFFFFFFF, B=1 -> Result=1. With Fuc=101011 -> Result=0. With Fuc=101010, A=80000000, B=1 -> Result=1.
- Logic ops with A=F0F0F0F0, B=0FF00FF0:
  - and -> 00F000F0
  - or -> FFF0FFF0
  - xor -> FF00FF00
  - nor -> 000F000F
  - ALUop=11 -> FFF0FFF0
  - Fuc=000000 (undefined) -> Result=0, zero=1.
- Back-to-back ops on consecutive cycles each appear exactly one cycle later. Asserting rst_n=0 between clock edges clears the outputs immediately, without waiting for clk.
